// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 load, per-round C/D rotation, PC-2 round keys.
// Optional key parity check enabled by defining KEY_PARITY_CHK_EN.
module des_key_sched (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic        i_rk_ready,
  output logic        o_busy,
  output logic        o_rk_valid,
  output logic [47:0] o_rk,
  output logic [3:0]  o_rk_idx,
  output logic        o_done,
  output logic        o_parity_err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [27:0] rol1(input logic [27:0] x);
    return {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rol2(input logic [27:0] x);
    return {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] ror1(input logic [27:0] x);
    return {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] ror2(input logic [27:0] x);
    return {x[1:0], x[27:2]};
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [55:0] cd;
  logic [55:0] cd_nxt;
  logic [55:0] pc1_key;
  logic [55:0] cd_fwd;
  logic [55:0] cd_rev;
  logic [3:0]  p;
  logic [3:0]  p_nxt;
  logic [3:0]  p_inc;
  logic        dec;
  logic        dec_nxt;
  logic        done_q;
  logic        done_nxt;
  logic        perr_q;
  logic        perr_nxt;
  logic        short_step;
  logic        key_ok;

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_key[55-g] = i_key[64-PC1[g]];
  end

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign o_rk[47-g] = cd[56-PC2[g]];
  end

`ifdef KEY_PARITY_CHK_EN
  logic [7:0] byte_odd;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_odd[b] = ^i_key[8*b +: 8];
  end
  assign key_ok = &byte_odd;
`else
  logic unused_par;
  assign unused_par = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                        i_key[24], i_key[16], i_key[8],  i_key[0]};
  assign key_ok = 1'b1;
`endif

  // Rounds 2, 9 and 16 use a single-bit rotation.
  assign p_inc      = p + 4'd1;
  assign short_step = (p_inc == 4'd1) || (p_inc == 4'd8) ||
                      (p_inc == 4'd15);

  assign cd_fwd = short_step ?
                  {rol1(cd[55:28]), rol1(cd[27:0])} :
                  {rol2(cd[55:28]), rol2(cd[27:0])};
  assign cd_rev = short_step ?
                  {ror1(cd[55:28]), ror1(cd[27:0])} :
                  {ror2(cd[55:28]), ror2(cd[27:0])};

  // Next-state: load on start, advance one round per handshake.
  always_comb begin
    state_nxt = state;
    cd_nxt    = cd;
    p_nxt     = p;
    dec_nxt   = dec;
    done_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (!key_ok) begin
            perr_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            p_nxt     = 4'd0;
            dec_nxt   = i_decrypt;
            cd_nxt    = i_decrypt ? pc1_key :
                        {rol1(pc1_key[55:28]), rol1(pc1_key[27:0])};
          end
        end
      end
      RUN: begin
        if (i_rk_ready) begin
          if (p == 4'd15) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            p_nxt  = p_inc;
            cd_nxt = dec ? cd_rev : cd_fwd;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cd     <= '0;
      p      <= '0;
      dec    <= 1'b0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cd     <= cd_nxt;
      p      <= p_nxt;
      dec    <= dec_nxt;
      done_q <= done_nxt;
      perr_q <= perr_nxt;
    end
  end

  assign o_busy       = (state == RUN);
  assign o_rk_valid   = (state == RUN);
  assign o_rk_idx     = dec ? (4'd15 - p) : p;
  assign o_done       = done_q;
  assign o_parity_err = perr_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized self-checking bench for des_key_sched.
// Reference computes each round key from cumulative shift totals.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic        rk_ready;
  logic        busy;
  logic        rk_valid;
  logic [47:0] rk;
  logic [3:0]  rk_idx;
  logic        done;
  logic        parity_err;

  int checks = 0;
  int errors = 0;

  logic [47:0] first_rk;
  logic [47:0] last_rk;

  always #5 clk = ~clk;

  des_key_sched dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_key        (key),
    .i_decrypt    (decrypt),
    .i_rk_ready   (rk_ready),
    .o_busy       (busy),
    .o_rk_valid   (rk_valid),
    .o_rk         (rk),
    .o_rk_idx     (rk_idx),
    .o_done       (done),
    .o_parity_err (parity_err)
  );

  int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Round key ri (0-based) from the total left rotation up to that round.
  function automatic logic [47:0] ref_rk(input logic [63:0] k, input int ri);
    logic [55:0] t;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] r;
    int s;
    for (int i = 0; i < 56; i++) t[55-i] = k[64-T_PC1[i]];
    s = 0;
    for (int j = 0; j <= ri; j++) s += SHIFTS[j];
    c = t[55:28];
    d = t[27:0];
    for (int j = 0; j < s; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    t = {c, d};
    for (int i = 0; i < 48; i++) r[47-i] = t[56-T_PC2[i]];
    return r;
  endfunction

  function automatic logic [63:0] make_key();
    logic [63:0] k;
    k = {$urandom(), $urandom()};
    for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
    return k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full sequence; leaves the bench in the o_done cycle.
  task automatic do_seq(input logic [63:0] k, input logic dm, input int mode,
                        input int inj_n, input logic [63:0] inj_key);
    int n;
    int cyc;
    int held;
    int ri;
    logic r;
    key     = k;
    decrypt = dm;
    start   = 1'b1;
    step();
    start   = 1'b0;
    key     = ~k;
    decrypt = ~dm;
    n = 0;
    cyc = 0;
    held = 0;
    while (n < 16 && cyc < 200) begin
      ri = dm ? 15 - n : n;
      checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL valid_busy n=%0d got=%b%b exp=11", n, rk_valid, busy);
      end
      checks++;
      if (rk !== ref_rk(k, ri)) begin
        errors++;
        $display("FAIL rk n=%0d got=%h exp=%h", n, rk, ref_rk(k, ri));
      end
      checks++;
      if (rk_idx !== ri[3:0]) begin
        errors++;
        $display("FAIL rk_idx n=%0d got=%0d exp=%0d", n, rk_idx, ri);
      end
      checks++;
      if (done !== 1'b0 || parity_err !== 1'b0) begin
        errors++;
        $display("FAIL done_perr_low n=%0d got=%b%b exp=00", n, done, parity_err);
      end
      if (n == 0) first_rk = rk;
      if (n == 15) last_rk = rk;
      r = 1'b1;
      if (mode == 1) begin
        if (n == 4 && held < 3) begin
          r = 1'b0;
          held++;
        end else if (n > 4) begin
          r = 1'($urandom_range(0, 1));
        end
      end
      if (n == inj_n) begin
        start   = 1'b1;
        key     = inj_key;
        decrypt = ~dm;
      end
      rk_ready = r;
      step();
      start   = 1'b0;
      key     = ~k;
      if (r) n++;
      cyc++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL handshakes got=%0d exp=16", n);
    end
    rk_ready = 1'b0;
    decrypt  = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle got done=%b busy=%b valid=%b exp=1,0,0",
               done, busy, rk_valid);
    end
  endtask

  task automatic check_done_low();
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b exp=0,0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk !== 48'h0 ||
        rk_idx !== 4'h0 || done !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset got busy=%b valid=%b rk=%h idx=%0d done=%b perr=%b exp=all 0",
               busy, rk_valid, rk, rk_idx, done, parity_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_encrypt();
    do_seq(64'h133457799BBCDFF1, 1'b0, 0, -1, 64'h0);
    checks++;
    if (first_rk !== 48'h1B02EFFC7072) begin
      errors++;
      $display("FAIL enc_k1 got=%h exp=1b02effc7072", first_rk);
    end
    checks++;
    if (last_rk !== 48'hCB3D8B0E17F5) begin
      errors++;
      $display("FAIL enc_k16 got=%h exp=cb3d8b0e17f5", last_rk);
    end
    check_done_low();
    for (int i = 0; i < 3; i++) begin
      do_seq(make_key(), 1'b0, 0, -1, 64'h0);
      check_done_low();
    end
  endtask

  task automatic test_decrypt();
    do_seq(64'h133457799BBCDFF1, 1'b1, 0, -1, 64'h0);
    checks++;
    if (first_rk !== 48'hCB3D8B0E17F5) begin
      errors++;
      $display("FAIL dec_first got=%h exp=cb3d8b0e17f5", first_rk);
    end
    checks++;
    if (last_rk !== 48'h1B02EFFC7072) begin
      errors++;
      $display("FAIL dec_last got=%h exp=1b02effc7072", last_rk);
    end
    check_done_low();
    for (int i = 0; i < 3; i++) begin
      do_seq(make_key(), 1'b1, 0, -1, 64'h0);
      check_done_low();
    end
  endtask

  task automatic test_weak_key();
    for (int m = 0; m < 2; m++) begin
      do_seq(64'h0101010101010101, 1'(m), 0, -1, 64'h0);
      checks++;
      if (first_rk !== 48'h0 || last_rk !== 48'h0) begin
        errors++;
        $display("FAIL weak_key mode=%0d got=%h/%h exp=0", m, first_rk, last_rk);
      end
      check_done_low();
    end
  endtask

  task automatic test_backpressure();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        do_seq(make_key(), 1'(m), 1, -1, 64'h0);
        check_done_low();
      end
    end
  endtask

  task automatic test_start_busy();
    for (int m = 0; m < 2; m++) begin
      do_seq(make_key(), 1'(m), 0, 7, make_key());
      check_done_low();
    end
  endtask

  task automatic test_back_to_back();
    do_seq(make_key(), 1'b0, 0, -1, 64'h0);
    do_seq(make_key(), 1'b1, 0, -1, 64'h0);
    do_seq(make_key(), 1'b0, 1, -1, 64'h0);
    check_done_low();
  endtask

  task automatic test_reset_mid();
    logic [63:0] k;
    k        = make_key();
    key      = k;
    decrypt  = 1'b0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    rk_ready = 1'b1;
    repeat (9) step();
    checks++;
    if (rk_idx !== 4'd9 || rk !== ref_rk(k, 9)) begin
      errors++;
      $display("FAIL mid_p9 got idx=%0d rk=%h exp idx=9 rk=%h",
               rk_idx, rk, ref_rk(k, 9));
    end
    rst_n    = 1'b0;
    rk_ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk !== 48'h0 ||
        rk_idx !== 4'h0 || done !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b valid=%b rk=%h idx=%0d done=%b exp=all 0",
               busy, rk_valid, rk, rk_idx, done);
    end
    rst_n = 1'b1;
    step();
    do_seq(k, 1'b0, 0, -1, 64'h0);
    check_done_low();
  endtask

`ifdef KEY_PARITY_CHK_EN
  task automatic test_parity();
    key     = 64'h0;
    decrypt = 1'b0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    checks++;
    if (parity_err !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse got perr=%b busy=%b valid=%b exp=1,0,0",
               parity_err, busy, rk_valid);
    end
    step();
    checks++;
    if (parity_err !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL parity_after got perr=%b busy=%b valid=%b done=%b exp=0",
               parity_err, busy, rk_valid, done);
    end
    do_seq(make_key(), 1'b0, 0, -1, 64'h0);
    check_done_low();
  endtask
`else
  task automatic test_no_parity();
    do_seq(64'h0, 1'b0, 0, -1, 64'h0);
    check_done_low();
    do_seq(64'hFFFFFFFFFFFFFFFF, 1'b1, 0, -1, 64'h0);
    check_done_low();
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    key      = 64'h0;
    decrypt  = 1'b0;
    rk_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_weak_key();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef KEY_PARITY_CHK_EN
    test_parity();
`else
    test_no_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

- Sequential DES key-schedule engine.
- Loads a 64-bit key and applies PC-1.
- Emits the 16 round keys (PC-2 of the C/D halves), one per valid/ready handshake.
- Order is K1..K16 for encryption, or K16..K1 for decryption, which uses right circular shifts.
- Sits between the key register and the round datapath, and drives the per-round C/D rotation (left 1/2, right 1/2) of the sub-key shift stage.

## Interface
- No parameters; round count fixed at 16, shift schedule fixed per FIPS 46-3.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  load request; accepted only when o_busy=0.
- i_key  in  64  DES key including parity bits (bit 63 = DES bit 1); sampled only on accepted start.
- i_decrypt  in  1  order select, sampled with i_key: 0 = K1..K16, 1 = K16..K1.
- i_rk_ready  in  1  consumer ready for current round key.
- o_busy  out  1  high from cycle after accepted start until last key handshake.
- o_rk_valid  out  1  round key valid.
- o_rk  out  48  round key; o_rk[47] = PC-2 output bit 1.
- o_rk_idx  out  4  DES round number minus 1 of o_rk (encrypt 0→15, decrypt 15→0).
- o_done  out  1  one-cycle pulse after last key accepted.
- o_parity_err  out  1  key parity error pulse; tied 0 unless the macro in Configuration is defined.

## Operation
- States: IDLE, RUN.
- Registers:
  - 56-bit CD: C = CD[55:28], D = CD[27:0].
  - 4-bit position counter p (0..15).
  - latched mode bit.
- o_rk = PC2(CD), combinational from the CD register. o_rk_valid = (state==RUN). o_busy = (state==RUN).
- IDLE + i_start=1:
  - encrypt: CD <= each half of PC1(i_key) rotated left 1 (CD1).
  - decrypt: CD <= PC1(i_key) (CD16 = CD0).
  - p <= 0; state <= RUN.
- RUN, handshake (o_rk_valid & i_rk_ready), p<15: p <= p+1, and CD is rotated per half for the next position:
  - encrypt: left 1 when the next p is 1 or 8 or 15, else left 2.
  - decrypt: right 1 when the next p is 1 or 8 or 15, else right 2.
- RUN, handshake at p=15: state <= IDLE; o_done=1 in the following cycle.
- o_rk_idx = p (encrypt) or 15-p (decrypt).
- Halves rotate independently; no bit crosses bit 28.
- Total rotation over 16 keys is 28 per half, so encrypt ends at CD16 = CD0 and decrypt ends at CD1.
- Boundary rules:
  - i_start while busy: ignored; no effect on key, mode or sequence.
  - valid & !ready: CD, p, o_rk and o_rk_idx held stable; o_rk_valid stays high.
  - i_start in the o_done cycle: accepted (o_busy=0).
  - reset mid-sequence: next cycle is IDLE, all outputs 0, sequence abandoned.

## Timing
- Reset values: o_busy=0, o_rk_valid=0, o_rk=0 (CD=0), o_rk_idx=0, o_done=0, o_parity_err=0.
- Start accepted at edge N: o_rk_valid=1 with the first key in cycle N+1.
- With i_rk_ready held high: keys in cycles N+1..N+16, o_done and o_busy=0 in cycle N+17.
- Minimum start-to-start spacing is 17 cycles.
- Each stall cycle adds exactly one cycle.
- No combinational path from i_rk_ready to o_rk or o_rk_valid.

## Configuration
- KEY_PARITY_CHK_EN defined:
  - On an accepted start, each i_key byte is checked for odd parity.
  - If any byte has even parity: o_parity_err=1 for cycle N+1 only; the key is not loaded and the block stays IDLE (o_busy=0, no keys, no o_done).
  - With valid parity, behaviour is as without the macro.
- KEY_PARITY_CHK_EN undefined: no check; o_parity_err constant 0; parity bits ignored (dropped by PC-1).

## Test plan
- Encrypt order, ready held high:
  - stimulus: i_key=0x133457799BBCDFF1, i_decrypt=0.
  - response: first key 0x1B02EFFC7072 (idx 0); key 16 is 0xCB3D8B0E17F5 (idx 15); o_done at N+17.
- Decrypt order: same key, i_decrypt=1 → first key 0xCB3D8B0E17F5 (idx 15); last key 0x1B02EFFC7072 (idx 0).
- Weak key: i_key=0x0101010101010101 in either mode → all 16 o_rk = 0x000000000000, parity error never asserted.
- Backpressure:
  - stimulus: i_rk_ready low for 3 cycles at p=4 and toggling afterwards.
  - response: o_rk and o_rk_idx stable while stalled, 16 handshakes total, o_done one cycle after the 16th.
- Start while busy: second i_start with a different key at p=7 → ignored; remaining keys still from the first key.
- Reset mid-sequence: i_rst_n=0 at p=9 → outputs 0 next cycle; a fresh start then yields the correct K1.
- With KEY_PARITY_CHK_EN, i_key=0x0000000000000000:
  - o_parity_err pulses in N+1.
  - o_busy and o_rk_valid stay 0.
